// File: rtl/down_counter_pkg.sv
// Shared definitions for the down_counter block: FSM state encoding and the
// default counter width.
package down_counter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : down_counter_pkg

// File: rtl/down_counter_if.sv
// Control/status bundle for down_counter. The master side drives the load,
// data and enable strobes. The slave side (the counter) returns the count,
// the terminal-count pulse and the busy flag.
interface down_counter_if #(
    parameter int WIDTH = down_counter_pkg::DEFAULT_WIDTH
);
    logic             load;
    logic [WIDTH-1:0] din;
    logic             en;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             busy;

    modport master (
        output load,
        output din,
        output en,
        input  q,
        input  tc,
        input  busy
    );

    modport slave (
        input  load,
        input  din,
        input  en,
        output q,
        output tc,
        output busy
    );
endinterface : down_counter_if

// File: rtl/down_counter.sv
// Loadable down counter with a three-state FSM (IDLE/RUN/DONE).
// In one-shot mode the counter stops in DONE after the terminal count.
// In auto-reload mode the counter restarts from the last loaded value.
// A load always takes priority over counting. A zero load parks the FSM in IDLE.
// All outputs come straight from registers.
module down_counter
    import down_counter_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter bit RELOAD = 1'b0
) (
    input  logic           clock,
    input  logic           clear,
    down_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q,     tc_d;
    logic             busy_q,   busy_d;

    // Next-state logic. A load wins over everything else. Counting only
    // happens in RUN with en high. tc is raised only on the 1 -> terminal step.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (bus.load) begin
            count_d  = bus.din;
            reload_d = bus.din;
            state_d  = (bus.din != ZERO) ? RUN : IDLE;
        end else begin
            case (state_q)
                RUN: begin
                    if (bus.en) begin
                        if (count_q > ONE) begin
                            count_d = count_q - ONE;
                        end else if (count_q == ONE) begin
                            tc_d = 1'b1;
                            if (RELOAD) begin
                                count_d = reload_q;
                            end else begin
                                count_d = ZERO;
                                state_d = DONE;
                            end
                        end else begin
                            // A zero count in RUN cannot occur through a load.
                            // Park safely instead of wrapping.
                            state_d = IDLE;
                        end
                    end
                end
                IDLE, DONE: begin
                    // en is ignored and the count holds.
                end
                default: begin
                    state_d = IDLE;
                    count_d = ZERO;
                end
            endcase
        end

        busy_d = (state_d == RUN);
    end

    // State, count, reload value and registered flags.
    // A low clear forces all of them to zero at once.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q  <= IDLE;
            count_q  <= ZERO;
            reload_q <= ZERO;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.q    = count_q;
    assign bus.tc   = tc_q;
    assign bus.busy = busy_q;

endmodule : down_counter

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter.
// Two instances share the same stimulus: a one-shot counter and an
// auto-reload counter. Both are compared against a behavioural model.
module tb_down_counter;

    localparam int W = 4;

    logic clock = 1'b0;
    logic clear;
    always #5 clock = ~clock;

    down_counter_if #(.WIDTH(W)) bus0 ();
    down_counter_if #(.WIDTH(W)) bus1 ();

    down_counter #(.WIDTH(W), .RELOAD(1'b0)) dut0 (
        .clock (clock),
        .clear (clear),
        .bus   (bus0.slave)
    );

    down_counter #(.WIDTH(W), .RELOAD(1'b1)) dut1 (
        .clock (clock),
        .clear (clear),
        .bus   (bus1.slave)
    );

    // Observed {q, tc, busy} per instance.
    logic [W+1:0] obs [2];
    assign obs[0] = {bus0.q, bus0.tc, bus0.busy};
    assign obs[1] = {bus1.q, bus1.tc, bus1.busy};

    int checks   = 0;
    int failures = 0;

    // Behavioural model. Index 0 is the one-shot instance; index 1 is the auto-reload instance.
    logic [W-1:0] m_q   [2];
    logic [W-1:0] m_rl  [2];
    bit           m_run [2];
    bit           m_tc  [2];

    function automatic logic [W+1:0] model_vec(int k);
        return {m_q[k], m_tc[k], m_run[k]};
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_q[k] = '0; m_rl[k] = '0; m_run[k] = 0; m_tc[k] = 0;
        end
    endfunction

    // Applies one clock edge of the model's rules.
    function automatic void model_edge(int k, bit l, logic [W-1:0] d, bit e);
        m_tc[k] = 0;
        if (l) begin
            m_q[k]   = d;
            m_rl[k]  = d;
            m_run[k] = (d != 0);
        end else if (m_run[k] && e) begin
            if (int'(m_q[k]) > 1) begin
                m_q[k] = m_q[k] - 1;
            end else begin
                m_tc[k] = 1;
                if (k == 1) begin
                    m_q[k] = m_rl[k];
                end else begin
                    m_q[k]   = 0;
                    m_run[k] = 0;
                end
            end
        end
    endfunction

    // Drives one cycle of inputs on both instances and advances the model.
    // Returns shortly after the edge so the outputs are sampled away from the edge.
    task automatic drive_cycle(input bit l, input logic [W-1:0] d, input bit e);
        @(negedge clock);
        bus0.load = l; bus0.din = d; bus0.en = e;
        bus1.load = l; bus1.din = d; bus1.en = e;
        @(posedge clock);
        model_edge(0, l, d, e);
        model_edge(1, l, d, e);
        #1;
    endtask

    task automatic test_reset();
        // Check the state while clear is asserted from time zero.
        clear = 1'b0;
        bus0.load = 0; bus0.din = '0; bus0.en = 0;
        bus1.load = 0; bus1.din = '0; bus1.en = 0;
        model_reset();
        #2;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== '0) begin
                failures++;
                $display("FAIL reset_initial dut%0d got=%h expected=0", k, obs[k]);
            end
        end
        @(negedge clock);
        clear = 1'b1;
        $display("test_reset: initial reset state checked");

        // Load 7, then count down to 5, then pulse clear between clock edges.
        drive_cycle(1, 4'd7, 1);
        drive_cycle(0, 4'd0, 1);
        drive_cycle(0, 4'd0, 1);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== {4'd5, 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL reset_precount dut%0d got=%h expected=%h", k, obs[k], {4'd5, 1'b0, 1'b1});
            end
        end
        #2 clear = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== '0) begin
                failures++;
                $display("FAIL reset_async dut%0d got=%h expected=0", k, obs[k]);
            end
        end
        @(negedge clock);
        clear = 1'b1;
        // With en held high and no load, the counters must stay idle.
        for (int c = 0; c < 3; c++) begin
            drive_cycle(0, 4'd6, 1);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== model_vec(k) || obs[k] !== '0) begin
                    failures++;
                    $display("FAIL reset_hold dut%0d cyc=%0d got=%h expected=0", k, c, obs[k]);
                end
            end
        end
        $display("test_reset: mid-count abort and idle hold checked");
    endtask

    task automatic test_one_shot();
        logic [W-1:0] exp_q  [5] = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd0};
        bit           exp_tc [5] = '{0, 0, 0, 1, 0};
        bit           exp_bz [5] = '{1, 1, 1, 0, 0};
        for (int c = 0; c < 5; c++) begin
            drive_cycle(c == 0, 4'd3, 1);
            checks++;
            if (obs[0] !== {exp_q[c], exp_tc[c], exp_bz[c]} || obs[0] !== model_vec(0)) begin
                failures++;
                $display("FAIL one_shot cyc=%0d got=%h expected=%h", c, obs[0], {exp_q[c], exp_tc[c], exp_bz[c]});
            end
        end
        $display("test_one_shot: load 3 count sequence checked");
    endtask

    task automatic test_auto_reload();
        logic [W-1:0] exp_q  [5] = '{4'd2, 4'd1, 4'd2, 4'd1, 4'd2};
        bit           exp_tc [5] = '{0, 0, 1, 0, 1};
        for (int c = 0; c < 5; c++) begin
            drive_cycle(c == 0, 4'd2, 1);
            checks++;
            if (obs[1] !== {exp_q[c], exp_tc[c], 1'b1} || obs[1] !== model_vec(1)) begin
                failures++;
                $display("FAIL auto_reload cyc=%0d got=%h expected=%h", c, obs[1], {exp_q[c], exp_tc[c], 1'b1});
            end
        end
        $display("test_auto_reload: load 2 reload sequence checked");
    endtask

    task automatic test_enable_gating();
        bit           en_seq [5] = '{0, 1, 0, 1, 0};
        logic [W-1:0] exp_q  [5] = '{4'd4, 4'd3, 4'd3, 4'd2, 4'd2};
        for (int c = 0; c < 5; c++) begin
            drive_cycle(c == 0, 4'd4, en_seq[c]);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== {exp_q[c], 1'b0, 1'b1}) begin
                    failures++;
                    $display("FAIL enable_gating dut%0d cyc=%0d got=%h expected=%h", k, c, obs[k], {exp_q[c], 1'b0, 1'b1});
                end
            end
        end
        $display("test_enable_gating: en toggle sequence checked");
    endtask

    task automatic test_priority();
        drive_cycle(1, 4'd1, 0);
        // Count is 1 in RUN; a load arrives together with en.
        drive_cycle(1, 4'd9, 1);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== {4'd9, 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL load_priority dut%0d got=%h expected=%h", k, obs[k], {4'd9, 1'b0, 1'b1});
            end
        end
        $display("test_priority: load over terminal count checked");
    endtask

    task automatic test_zero_load();
        for (int c = 0; c < 4; c++) begin
            drive_cycle(c == 0, 4'd0, 1);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== '0) begin
                    failures++;
                    $display("FAIL zero_load dut%0d cyc=%0d got=%h expected=0", k, c, obs[k]);
                end
            end
        end
        $display("test_zero_load: zero load parks idle checked");
    endtask

    task automatic test_random();
        int errs_before;
        errs_before = failures;
        for (int c = 0; c < 300; c++) begin
            bit           l;
            logic [W-1:0] d;
            bit           e;
            l = ($urandom_range(0, 7) == 0);
            d = W'($urandom_range(0, (1 << W) - 1));
            if ($urandom_range(0, 3) == 0) d = 4'd1;
            e = ($urandom_range(0, 3) != 0);
            drive_cycle(l, d, e);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== model_vec(k)) begin
                    failures++;
                    $display("FAIL random dut%0d cyc=%0d load=%0b din=%0d en=%0b got=%h expected=%h",
                             k, c, l, d, e, obs[k], model_vec(k));
                end
            end
        end
        $display("test_random: 300 cycles, %0d new failures", failures - errs_before);
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_enable_gating();
        test_priority();
        test_zero_load();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_down_counter
